// File: rtl/ram_read_arbiter_if.sv
// ram_read_arbiter_if: requester, response and RAM read-port signals of the read arbiter
interface ram_read_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              flush;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (
        output if_req, if_addr, mem_req, mem_addr, flush, ram_rd_data,
        input  if_gnt, if_rsp_valid, if_rsp_data, mem_gnt, mem_rsp_valid, mem_rsp_data,
        input  ram_rd_en, ram_rd_addr
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_addr, flush, ram_rd_data,
        output if_gnt, if_rsp_valid, if_rsp_data, mem_gnt, mem_rsp_valid, mem_rsp_data,
        output ram_rd_en, ram_rd_addr
    );
endinterface

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: shares one RAM read port between fetch and load; RAM_ARB_STALL_COUNTERS_EN adds stall counters
module ram_read_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int RD_LATENCY     = 1,
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    ram_read_arbiter_if.slave bus
`ifdef RAM_ARB_STALL_COUNTERS_EN
    ,
    output logic [31:0]       if_stall_cnt,
    output logic [31:0]       mem_stall_cnt
`endif
);
    localparam logic [3:0] STREAK_MAX = 4'(MEM_STREAK_MAX);

    logic                streak_ok;
    logic                mem_gnt;
    logic                if_gnt;
    logic [3:0]          streak;
    logic [RD_LATENCY:0] tag_v;
    logic [RD_LATENCY:0] tag_m;
    logic [RD_LATENCY:0] tag_v_nxt;

    // Load wins unless it has starved a waiting fetch; the shifted tags drop fetch reads on flush
    always_comb begin
        streak_ok = streak < STREAK_MAX;
        mem_gnt   = !reset && bus.mem_req && (streak_ok || !bus.if_req);
        if_gnt    = !reset && !mem_gnt && bus.if_req && !bus.flush;
        tag_v_nxt = {tag_v[RD_LATENCY-1:0] & (tag_m[RD_LATENCY-1:0] | {RD_LATENCY{!bus.flush}}),
                     mem_gnt | if_gnt};
    end

    assign bus.mem_gnt       = mem_gnt;
    assign bus.if_gnt        = if_gnt;
    assign bus.if_rsp_data   = bus.ram_rd_data;
    assign bus.mem_rsp_data  = bus.ram_rd_data;
    assign bus.mem_rsp_valid = !reset && tag_v[RD_LATENCY] && tag_m[RD_LATENCY];
    assign bus.if_rsp_valid  = !reset && !bus.flush && tag_v[RD_LATENCY] && !tag_m[RD_LATENCY];

    // Streak tracking, RAM request register and owner tag shift pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            streak          <= '0;
            bus.ram_rd_en   <= 1'b0;
            bus.ram_rd_addr <= '0;
            tag_v           <= '0;
            tag_m           <= '0;
        end else begin
            streak          <= (if_gnt || !bus.if_req) ? 4'd0 : (mem_gnt && streak_ok) ? streak + 4'd1 : streak;
            bus.ram_rd_en   <= mem_gnt | if_gnt;
            bus.ram_rd_addr <= mem_gnt ? bus.mem_addr : if_gnt ? bus.if_addr : bus.ram_rd_addr;
            tag_v           <= tag_v_nxt;
            tag_m           <= {tag_m[RD_LATENCY-1:0], mem_gnt};
        end
    end

`ifdef RAM_ARB_STALL_COUNTERS_EN
    // Cycles each requester waited; fetch waits during flush are intentional and not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            if_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if_stall_cnt  <= if_stall_cnt + 32'(bus.if_req && !if_gnt && !bus.flush);
            mem_stall_cnt <= mem_stall_cnt + 32'(bus.mem_req && !mem_gnt);
        end
    end
`endif
endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter: directed checks of grants, issue, response routing, flush and reset
module tb_ram_read_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    ram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef RAM_ARB_STALL_COUNTERS_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] mem_stall_cnt;
`endif

    ram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .MEM_STREAK_MAX(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef RAM_ARB_STALL_COUNTERS_EN
        ,
        .if_stall_cnt(if_stall_cnt),
        .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [15:0] a);
        return {~a, a};
    endfunction

    // One-cycle synchronous RAM model
    always @(posedge clk) bus.ram_rd_data <= bus.ram_rd_en ? word(bus.ram_rd_addr) : 32'h0;

    task automatic drive(input logic rs, input logic ir, input logic [15:0] ia,
                         input logic mr, input logic [15:0] ma, input logic fl);
        @(posedge clk);
        #1;
        reset = rs;
        bus.if_req = ir;
        bus.if_addr = ia;
        bus.mem_req = mr;
        bus.mem_addr = ma;
        bus.flush = fl;
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            drive(1, 1, 16'h5, 1, 16'h6, 0);
            checks++;
            if (bus.if_gnt !== 1'b0 || bus.mem_gnt !== 1'b0) begin
                failures++;
                $display("FAIL reset_gnt c=%0d got if=%b mem=%b exp 0 0", c, bus.if_gnt, bus.mem_gnt);
            end
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 16'h0, 0, 16'h0, 0);
            checks++;
            if (bus.ram_rd_en !== 1'b0 || bus.ram_rd_addr !== 16'h0) begin
                failures++;
                $display("FAIL reset_ram c=%0d got en=%b addr=%h exp 0 0000", c, bus.ram_rd_en, bus.ram_rd_addr);
            end
            checks++;
            if (bus.if_rsp_valid !== 1'b0 || bus.mem_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid c=%0d got if=%b mem=%b exp 0 0", c, bus.if_rsp_valid, bus.mem_rsp_valid);
            end
        end
    endtask

    task automatic test_fetch_only;
        logic [15:0] a;
        logic [15:0] p;
        for (int c = 0; c < 5; c++) begin
            a = 16'(32'h10 + c);
            drive(0, c < 3, a, 0, 16'h0, 0);
            checks++;
            if (bus.if_gnt !== (c < 3) || bus.mem_gnt !== 1'b0) begin
                failures++;
                $display("FAIL fetch_gnt c=%0d got if=%b mem=%b exp %b 0", c, bus.if_gnt, bus.mem_gnt, c < 3);
            end
            if (c >= 1 && c <= 3) begin
                p = 16'(32'h10 + c - 1);
                checks++;
                if (bus.ram_rd_en !== 1'b1 || bus.ram_rd_addr !== p) begin
                    failures++;
                    $display("FAIL fetch_issue c=%0d got en=%b addr=%h exp 1 %h", c, bus.ram_rd_en, bus.ram_rd_addr, p);
                end
            end
            checks++;
            if (bus.if_rsp_valid !== (c >= 2) || bus.mem_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL fetch_valid c=%0d got if=%b mem=%b exp %b 0", c, bus.if_rsp_valid, bus.mem_rsp_valid, c >= 2);
            end
            if (c >= 2) begin
                p = 16'(32'h10 + c - 2);
                checks++;
                if (bus.if_rsp_data !== word(p)) begin
                    failures++;
                    $display("FAIL fetch_data c=%0d got %h exp %h", c, bus.if_rsp_data, word(p));
                end
            end
        end
    endtask

    task automatic test_contention;
        logic ef, em, rf, rm;
        for (int c = 0; c < 17; c++) begin
            drive(0, c < 15, 16'h200, c < 15, 16'h100, 0);
            ef = (c < 15) && (c % 5 == 4);
            em = (c < 15) && !ef;
            checks++;
            if (bus.if_gnt !== ef || bus.mem_gnt !== em) begin
                failures++;
                $display("FAIL contention_gnt c=%0d got if=%b mem=%b exp %b %b", c, bus.if_gnt, bus.mem_gnt, ef, em);
            end
            if (c >= 2) begin
                rf = ((c - 2) % 5 == 4);
                rm = !rf;
                checks++;
                if (bus.if_rsp_valid !== rf || bus.mem_rsp_valid !== rm) begin
                    failures++;
                    $display("FAIL contention_rsp c=%0d got if=%b mem=%b exp %b %b", c, bus.if_rsp_valid, bus.mem_rsp_valid, rf, rm);
                end
                checks++;
                if (rf ? bus.if_rsp_data !== word(16'h200) : bus.mem_rsp_data !== word(16'h100)) begin
                    failures++;
                    $display("FAIL contention_data c=%0d got if=%h mem=%h owner_fetch=%b", c, bus.if_rsp_data, bus.mem_rsp_data, rf);
                end
            end
        end
    endtask

    task automatic test_mem_only;
        logic [15:0] p;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 16'h0, c < 6, 16'(32'h70 + c), 0);
            checks++;
            if (bus.mem_gnt !== (c < 6) || bus.if_gnt !== 1'b0) begin
                failures++;
                $display("FAIL mem_gnt c=%0d got mem=%b if=%b exp %b 0", c, bus.mem_gnt, bus.if_gnt, c < 6);
            end
            if (c >= 2) begin
                p = 16'(32'h70 + c - 2);
                checks++;
                if (bus.mem_rsp_valid !== 1'b1 || bus.mem_rsp_data !== word(p) || bus.if_rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL mem_rsp c=%0d got v=%b d=%h ifv=%b exp 1 %h 0", c, bus.mem_rsp_valid, bus.mem_rsp_data, bus.if_rsp_valid, word(p));
                end
            end
        end
    endtask

    task automatic test_flush;
        logic eg;
        for (int c = 0; c < 5; c++) begin
            drive(0, c < 3, c == 0 ? 16'h30 : 16'h31, 0, 16'h0, c == 1);
            eg = (c == 0) || (c == 2);
            checks++;
            if (bus.if_gnt !== eg) begin
                failures++;
                $display("FAIL flush_gnt c=%0d got %b exp %b", c, bus.if_gnt, eg);
            end
            checks++;
            if (bus.if_rsp_valid !== (c == 4) || bus.mem_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_rsp c=%0d got if=%b mem=%b exp %b 0", c, bus.if_rsp_valid, bus.mem_rsp_valid, c == 4);
            end
            if (c == 4) begin
                checks++;
                if (bus.if_rsp_data !== word(16'h31)) begin
                    failures++;
                    $display("FAIL flush_data got %h exp %h", bus.if_rsp_data, word(16'h31));
                end
            end
        end
    endtask

    task automatic test_flush_mem;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 16'h0, c == 0, 16'h40, c == 1 || c == 2);
            checks++;
            if (bus.mem_rsp_valid !== (c == 2) || bus.if_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_mem_rsp c=%0d got mem=%b if=%b exp %b 0", c, bus.mem_rsp_valid, bus.if_rsp_valid, c == 2);
            end
            if (c == 2) begin
                checks++;
                if (bus.mem_rsp_data !== word(16'h40)) begin
                    failures++;
                    $display("FAIL flush_mem_data got %h exp %h", bus.mem_rsp_data, word(16'h40));
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 16'(32'h60 + c), 0, 16'h0, 0);
            checks++;
            if (bus.if_gnt !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_gnt c=%0d got %b exp 1", c, bus.if_gnt);
            end
        end
        checks++;
        if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== word(16'h60)) begin
            failures++;
            $display("FAIL reset_mid_first got v=%b d=%h exp 1 %h", bus.if_rsp_valid, bus.if_rsp_data, word(16'h60));
        end
        drive(1, 1, 16'h63, 1, 16'h64, 0);
        checks++;
        if (bus.if_gnt !== 1'b0 || bus.mem_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_gnt_sup got if=%b mem=%b exp 0 0", bus.if_gnt, bus.mem_gnt);
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 16'h0, 0, 16'h0, 0);
            if (c == 0) begin
                checks++;
                if (bus.ram_rd_en !== 1'b0 || bus.ram_rd_addr !== 16'h0) begin
                    failures++;
                    $display("FAIL reset_mid_ram got en=%b addr=%h exp 0 0000", bus.ram_rd_en, bus.ram_rd_addr);
                end
            end
            checks++;
            if (bus.if_rsp_valid !== 1'b0 || bus.mem_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_valid c=%0d got if=%b mem=%b exp 0 0", c, bus.if_rsp_valid, bus.mem_rsp_valid);
            end
        end
    endtask

`ifdef RAM_ARB_STALL_COUNTERS_EN
    task automatic test_stall_counters;
        logic [31:0] bi, bm;
        drive(0, 0, 16'h0, 0, 16'h0, 0);
        bi = if_stall_cnt;
        bm = mem_stall_cnt;
        for (int c = 0; c < 10; c++) drive(0, 1, 16'h80, 1, 16'h90, 0);
        drive(0, 0, 16'h0, 0, 16'h0, 0);
        checks++;
        if (if_stall_cnt - bi !== 32'd8 || mem_stall_cnt - bm !== 32'd2) begin
            failures++;
            $display("FAIL stall_cnt got if=%0d mem=%0d exp 8 2", if_stall_cnt - bi, mem_stall_cnt - bm);
        end
    endtask
`endif

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.mem_req = 1'b0;
        bus.mem_addr = '0;
        bus.flush = 1'b0;
        test_reset;
        test_fetch_only;
        test_contention;
        test_mem_only;
        test_flush;
        test_flush_mem;
        test_reset_mid;
`ifdef RAM_ARB_STALL_COUNTERS_EN
        test_stall_counters;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
